// File: rtl/accumulation_differentiator.sv
// Recovers per-step summands from a stream of running sums (current - previous mod 2^WIDTH),
// with a two-entry output skid buffer and a global clock enable.
module accumulation_differentiator #(
  parameter int WIDTH         = 8,
  parameter bit FIRST_IS_BASE = 1'b1
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_CLK_EN,
  input  logic             i_ACC_VALID,
  output logic             o_ACC_READY,
  input  logic [WIDTH-1:0] i_ACCUMULATION,
  input  logic             i_RESYNC,
  output logic             o_SUM_VALID,
  input  logic             i_SUM_READY,
  output logic [WIDTH-1:0] o_SUMMAND,
  output logic             o_FIRST
);

  typedef enum logic {
    S_UNPRIMED = 1'b0,
    S_PRIMED   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             head_first_q, head_first_d;
  logic             tail_first_q, tail_first_d;

  logic             accept_s;
  logic             pop_s;
  logic             push_s;
  logic             base_beat_s;
  logic [WIDTH-1:0] new_val_s;

  assign o_ACC_READY = (count_q != 2'd2);
  assign o_SUM_VALID = (count_q != 2'd0);
  assign o_SUMMAND   = head_q;
  assign o_FIRST     = head_first_q;

  // Next-state logic: base tracking, difference, and head/tail buffer update.
  always_comb begin
    accept_s    = i_CLK_EN & i_ACC_VALID & o_ACC_READY;
    pop_s       = i_CLK_EN & o_SUM_VALID & i_SUM_READY;
    base_beat_s = (state_q == S_UNPRIMED) | i_RESYNC;
    // A base beat differences against zero, so the sample itself is the summand.
    push_s      = accept_s & ~(base_beat_s & FIRST_IS_BASE);
    new_val_s   = base_beat_s ? i_ACCUMULATION : (i_ACCUMULATION - prev_q);

    state_d      = state_q;
    prev_d       = prev_q;
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    head_first_d = head_first_q;
    tail_first_d = tail_first_q;

    if (accept_s) begin
      prev_d  = i_ACCUMULATION;
      state_d = S_PRIMED;
    end else begin
      prev_d  = prev_q;
      state_d = state_q;
    end

    case ({push_s, pop_s})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_d       = new_val_s;
          head_first_d = base_beat_s;
        end else begin
          tail_d       = new_val_s;
          tail_first_d = base_beat_s;
        end
      end
      2'b01: begin
        count_d      = count_q - 2'd1;
        head_d       = tail_q;
        head_first_d = tail_first_q;
      end
      2'b11: begin
        // Push needs count<2 and pop needs count>0, so count is 1: new entry becomes head.
        count_d      = count_q;
        head_d       = new_val_s;
        head_first_d = base_beat_s;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // State registers with asynchronous reset flushing the buffer and base.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q      <= S_UNPRIMED;
      count_q      <= 2'd0;
      prev_q       <= {WIDTH{1'b0}};
      head_q       <= {WIDTH{1'b0}};
      tail_q       <= {WIDTH{1'b0}};
      head_first_q <= 1'b0;
      tail_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      prev_q       <= prev_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      head_first_q <= head_first_d;
      tail_first_q <= tail_first_d;
    end
  end

endmodule

// File: tb/tb_accumulation_differentiator.sv
// Directed self-checking bench: one instance with FIRST_IS_BASE=1 (b_*) and one with FIRST_IS_BASE=0 (z_*).
module tb_accumulation_differentiator;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       b_valid, b_ready, b_resync, b_sv, b_sr, b_first;
  logic [7:0] b_acc, b_sum;
  logic       z_valid, z_ready, z_resync, z_sv, z_sr, z_first;
  logic [7:0] z_acc, z_sum;
  int         total;
  int         bad;

  accumulation_differentiator #(.WIDTH(8), .FIRST_IS_BASE(1'b1)) dut_b (
    .i_CLK(clk), .i_RESET(rst), .i_CLK_EN(clk_en),
    .i_ACC_VALID(b_valid), .o_ACC_READY(b_ready), .i_ACCUMULATION(b_acc),
    .i_RESYNC(b_resync), .o_SUM_VALID(b_sv), .i_SUM_READY(b_sr),
    .o_SUMMAND(b_sum), .o_FIRST(b_first)
  );

  accumulation_differentiator #(.WIDTH(8), .FIRST_IS_BASE(1'b0)) dut_z (
    .i_CLK(clk), .i_RESET(rst), .i_CLK_EN(clk_en),
    .i_ACC_VALID(z_valid), .o_ACC_READY(z_ready), .i_ACCUMULATION(z_acc),
    .i_RESYNC(z_resync), .o_SUM_VALID(z_sv), .i_SUM_READY(z_sr),
    .o_SUMMAND(z_sum), .o_FIRST(z_first)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for ready, and return just after the accepting edge.
  task automatic send(input bit use_z, input logic [7:0] v, input logic rs);
    int n;
    n = 0;
    if (use_z) begin z_valid = 1'b1; z_acc = v; z_resync = rs; end
    else begin b_valid = 1'b1; b_acc = v; b_resync = rs; end
    while (!(use_z ? z_ready : b_ready) && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL send_timeout: beat %h never accepted (waited %0d cycles, required < 20)", v, n);
    end
    step();
    if (use_z) begin z_valid = 1'b0; z_resync = 1'b0; end
    else begin b_valid = 1'b0; b_resync = 1'b0; end
  endtask

  task automatic test_reset();
    total++;
    if (b_sv !== 1'b0 || b_sum !== 8'h00 || b_first !== 1'b0 || b_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_b: valid=%b summand=%h first=%b ready=%b, required 0 00 0 1", b_sv, b_sum, b_first, b_ready);
    end
    total++;
    if (z_sv !== 1'b0 || z_sum !== 8'h00 || z_first !== 1'b0 || z_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_z: valid=%b summand=%h first=%b ready=%b, required 0 00 0 1", z_sv, z_sum, z_first, z_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] vin [0:2];
    logic       ev  [0:2];
    logic [7:0] es  [0:2];
    vin = '{8'h78, 8'hFF, 8'h7F};
    ev  = '{1'b0, 1'b1, 1'b1};
    es  = '{8'h00, 8'h87, 8'h80};
    for (int i = 0; i < 3; i++) begin
      send(1'b0, vin[i], 1'b0);
      total++;
      if (b_sv !== ev[i] || (ev[i] && (b_sum !== es[i] || b_first !== 1'b0))) begin
        bad++;
        $display("FAIL basic[%0d]: valid=%b summand=%h first=%b, required valid=%b summand=%h first=0",
                 i, b_sv, b_sum, b_first, ev[i], es[i]);
      end
    end
    step();
    total++;
    if (b_sv !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain: valid=%b, required 0", b_sv);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] vin [0:3];
    logic       rs  [0:3];
    logic       ev  [0:3];
    logic [7:0] es  [0:3];
    vin = '{8'hF0, 8'h10, 8'h10, 8'hF0};
    rs  = '{1'b1, 1'b0, 1'b1, 1'b0};
    ev  = '{1'b0, 1'b1, 1'b0, 1'b1};
    es  = '{8'h00, 8'h20, 8'h00, 8'hE0};
    for (int i = 0; i < 4; i++) begin
      send(1'b0, vin[i], rs[i]);
      total++;
      if (b_sv !== ev[i] || (ev[i] && b_sum !== es[i])) begin
        bad++;
        $display("FAIL wrap[%0d]: valid=%b summand=%h, required valid=%b summand=%h", i, b_sv, b_sum, ev[i], es[i]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    b_sr = 1'b0;
    send(1'b0, 8'h00, 1'b1);
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h03, 1'b0);
    total++;
    if (b_sv !== 1'b1 || b_sum !== 8'h01 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_full: valid=%b summand=%h ready=%b, required 1 01 0", b_sv, b_sum, b_ready);
    end
    b_valid = 1'b1; b_acc = 8'h06;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (b_ready !== 1'b0 || b_sum !== 8'h01 || b_sv !== 1'b1) begin
        bad++;
        $display("FAIL bp_stall[%0d]: ready=%b summand=%h valid=%b, required 0 01 1", i, b_ready, b_sum, b_sv);
      end
    end
    b_sr = 1'b1;
    step();
    total++;
    if (b_sv !== 1'b1 || b_sum !== 8'h02 || b_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_pop1: valid=%b summand=%h ready=%b, required 1 02 1", b_sv, b_sum, b_ready);
    end
    step();
    b_valid = 1'b0;
    total++;
    if (b_sv !== 1'b1 || b_sum !== 8'h03) begin
      bad++;
      $display("FAIL bp_pop2: valid=%b summand=%h, required 1 03", b_sv, b_sum);
    end
    step();
    total++;
    if (b_sv !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: valid=%b, required 0", b_sv);
    end
  endtask

  task automatic test_clock_enable();
    send(1'b0, 8'h50, 1'b1);
    send(1'b0, 8'h55, 1'b0);
    clk_en = 1'b0;
    b_valid = 1'b1; b_acc = 8'h60;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (b_sv !== 1'b1 || b_sum !== 8'h05 || b_ready !== 1'b1) begin
        bad++;
        $display("FAIL ce_hold[%0d]: valid=%b summand=%h ready=%b, required 1 05 1", i, b_sv, b_sum, b_ready);
      end
    end
    clk_en = 1'b1;
    step();
    b_valid = 1'b0;
    total++;
    if (b_sv !== 1'b1 || b_sum !== 8'h0B) begin
      bad++;
      $display("FAIL ce_resume: valid=%b summand=%h, required 1 0b", b_sv, b_sum);
    end
    step();
  endtask

  task automatic test_resync();
    logic [7:0] vin  [0:3];
    logic       rs   [0:3];
    logic       bv   [0:3];
    logic [7:0] bs   [0:3];
    logic [7:0] zs   [0:3];
    logic       zf   [0:3];
    vin = '{8'h10, 8'h20, 8'h90, 8'h95};
    rs  = '{1'b0, 1'b0, 1'b1, 1'b0};
    bv  = '{1'b0, 1'b1, 1'b0, 1'b1};
    bs  = '{8'h00, 8'h10, 8'h00, 8'h05};
    zs  = '{8'h10, 8'h10, 8'h90, 8'h05};
    zf  = '{1'b1, 1'b0, 1'b1, 1'b0};
    // The b instance is primed from earlier tests, so resync the first beat into a new base.
    for (int i = 0; i < 4; i++) begin
      send(1'b0, vin[i], (i == 0) ? 1'b1 : rs[i]);
      total++;
      if (b_sv !== bv[i] || (bv[i] && b_sum !== bs[i])) begin
        bad++;
        $display("FAIL resync_b[%0d]: valid=%b summand=%h, required valid=%b summand=%h", i, b_sv, b_sum, bv[i], bs[i]);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b1, vin[i], rs[i]);
      total++;
      if (z_sv !== 1'b1 || z_sum !== zs[i] || z_first !== zf[i]) begin
        bad++;
        $display("FAIL resync_z[%0d]: valid=%b summand=%h first=%b, required 1 %h %b", i, z_sv, z_sum, z_first, zs[i], zf[i]);
      end
    end
    step();
  endtask

  task automatic test_async_reset();
    b_sr = 1'b0;
    send(1'b0, 8'h00, 1'b1);
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h03, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (b_sv !== 1'b0 || b_ready !== 1'b1 || b_sum !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: valid=%b ready=%b summand=%h, required 0 1 00", b_sv, b_ready, b_sum);
    end
    step();
    rst = 1'b0;
    b_sr = 1'b1;
    send(1'b0, 8'h42, 1'b0);
    total++;
    if (b_sv !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_base: valid=%b, required 0", b_sv);
    end
    send(1'b0, 8'h45, 1'b0);
    total++;
    if (b_sv !== 1'b1 || b_sum !== 8'h03 || b_first !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_diff: valid=%b summand=%h first=%b, required 1 03 0", b_sv, b_sum, b_first);
    end
    step();
  endtask

  initial begin
    total = 0; bad = 0;
    clk = 1'b0; rst = 1'b1; clk_en = 1'b1;
    b_valid = 1'b0; b_acc = 8'h00; b_resync = 1'b0; b_sr = 1'b1;
    z_valid = 1'b0; z_acc = 8'h00; z_resync = 1'b0; z_sr = 1'b1;
    step();
    step();
    rst = 1'b0;
    test_reset();
    step();
    test_basic();
    test_wrap();
    test_backpressure();
    test_clock_enable();
    test_resync();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
